// File: rtl/rv_instr_encoder_loader_pkg.sv
// Shared constants for the RV32I field encoder / instruction loader.
// NOP_PAD_EN adds the PAD state used to fill memory with NOPs.
package rv_enc_pkg;

  localparam logic [3:0] CLS_ADD = 4'd0;
  localparam logic [3:0] CLS_SUB = 4'd1;
  localparam logic [3:0] CLS_AND = 4'd2;
  localparam logic [3:0] CLS_OR  = 4'd3;
  localparam logic [3:0] CLS_SLT = 4'd4;
  localparam logic [3:0] CLS_LW  = 4'd5;
  localparam logic [3:0] CLS_SW  = 4'd6;
  localparam logic [3:0] CLS_BEQ = 4'd7;
  localparam logic [3:0] CLS_JAL = 4'd8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CLASS = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FULL,
`ifdef NOP_PAD_EN
    S_PAD,
`endif
    S_ERR
  } state_e;

  function automatic logic [31:0] r_type(
    input logic [6:0] f7,
    input logic [4:0] rs2,
    input logic [4:0] rs1,
    input logic [2:0] f3,
    input logic [4:0] rd
  );
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

endpackage

// File: rtl/rv_instr_encoder_loader_if.sv
// Request channel, memory write port and status of the loader.
// master = request source / memory side, slave = loader.
interface rv_instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              iValid;
  logic              oReady;
  logic [3:0]        iClass;
  logic [4:0]        iRd;
  logic [4:0]        iRs1;
  logic [4:0]        iRs2;
  logic [20:0]       iImm;
  logic              oWrEn;
  logic [ADDR_W-1:0] oWrAddr;
  logic [31:0]       oWrData;
  logic              iWrReady;
  logic [ADDR_W:0]   oCount;
  logic              oBusy;
  logic              oFull;
  logic              oErr;
  logic [1:0]        oErrCode;

  modport master (
    output iValid, iClass, iRd, iRs1, iRs2, iImm, iWrReady,
    input  oReady, oWrEn, oWrAddr, oWrData, oCount,
    input  oBusy, oFull, oErr, oErrCode
  );

  modport slave (
    input  iValid, iClass, iRd, iRs1, iRs2, iImm, iWrReady,
    output oReady, oWrEn, oWrAddr, oWrData, oCount,
    output oBusy, oFull, oErr, oErrCode
  );
endinterface

// File: rtl/rv_instr_encoder_loader_enc.sv
// Combinational field -> RV32I word encoder with class/range checks.
module rv_field_encoder
  import rv_enc_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);
  logic i12_ok;
  logic b13_ok;

  // sign-extension bits above the field must all match
  assign i12_ok = (&imm[20:11]) | ~(|imm[20:11]);
  assign b13_ok = (&imm[20:12]) | ~(|imm[20:12]);

  always_comb begin
    word      = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (cls)
      CLS_ADD: word = r_type(F7_ZERO, rs2, rs1, F3_ADD, rd);
      CLS_SUB: word = r_type(F7_SUB, rs2, rs1, F3_ADD, rd);
      CLS_AND: word = r_type(F7_ZERO, rs2, rs1, F3_AND, rd);
      CLS_OR:  word = r_type(F7_ZERO, rs2, rs1, F3_OR, rd);
      CLS_SLT: word = r_type(F7_ZERO, rs2, rs1, F3_SLT, rd);
      CLS_LW: begin
        word = {imm[11:0], rs1, F3_W, rd, OP_LOAD};
        range_err = !i12_ok;
      end
      CLS_SW: begin
        word = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OP_STORE};
        range_err = !i12_ok;
      end
      CLS_BEQ: begin
        word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                imm[4:1], imm[11], OP_BRANCH};
        range_err = !b13_ok || imm[0];
      end
      CLS_JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        range_err = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/rv_instr_encoder_loader.sv
// Encodes field-level requests and streams them into instruction memory.
// NOP_PAD_EN adds iFlush and the NOP-fill PAD state.
module rv_instr_encoder_loader
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input logic iCLK,
  input logic iRST_n,
  input logic iStart,
`ifdef NOP_PAD_EN
  input logic iFlush,
`endif
  rv_instr_encoder_loader_if.slave bus
);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   issued;
  logic [31:0]       enc_word;
  logic [31:0]       issue_word;
  logic              illegal;
  logic              range_err;
  logic              bad;
  logic              stall;
  logic              room;
  logic              last;
  logic              accept;
  logic              issue;
  logic              wr_done;
  logic              flush;

  rv_field_encoder u_enc (
    .cls       (bus.iClass),
    .rd        (bus.iRd),
    .rs1       (bus.iRs1),
    .rs2       (bus.iRs2),
    .imm       (bus.iImm),
    .word      (enc_word),
    .illegal   (illegal),
    .range_err (range_err)
  );

`ifdef NOP_PAD_EN
  assign flush = iFlush;
`else
  assign flush = 1'b0;
`endif

  assign stall   = bus.oWrEn && !bus.iWrReady;
  assign wr_done = bus.oWrEn && bus.iWrReady;
  assign room    = issued < DEPTH_C;
  assign last    = issued == DEPTH_C - 1'b1;
  assign bad     = illegal || range_err;

  assign bus.oReady = (state == S_LOAD) && !iStart && !flush
                    && !stall && room;
  assign accept     = bus.iValid && bus.oReady;

  always_comb begin
    issue      = accept && !bad;
    issue_word = enc_word;
`ifdef NOP_PAD_EN
    if (state == S_PAD) begin
      issue      = !stall && room;
      issue_word = NOP_WORD;
    end
`endif
  end

  assign bus.oBusy = state != S_IDLE;
  assign bus.oFull = state == S_FULL;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state        <= S_IDLE;
      ptr          <= BASE_C;
      issued       <= '0;
      bus.oWrEn    <= 1'b0;
      bus.oWrAddr  <= BASE_C;
      bus.oWrData  <= '0;
      bus.oCount   <= '0;
      bus.oErr     <= 1'b0;
      bus.oErrCode <= ERR_NONE;
    end else if (iStart) begin
      // abort drops any pending write
      state        <= S_LOAD;
      ptr          <= BASE_C;
      issued       <= '0;
      bus.oWrEn    <= 1'b0;
      bus.oWrAddr  <= BASE_C;
      bus.oCount   <= '0;
      bus.oErr     <= 1'b0;
      bus.oErrCode <= ERR_NONE;
    end else begin
      if (wr_done) begin
        bus.oWrEn  <= 1'b0;
        bus.oCount <= bus.oCount + 1'b1;
      end
      if (issue) begin
        bus.oWrEn   <= 1'b1;
        bus.oWrAddr <= ptr;
        bus.oWrData <= issue_word;
        ptr         <= ptr + 1'b1;
        issued      <= issued + 1'b1;
        if (last) state <= S_FULL;
      end
      if (state == S_LOAD) begin
        if (flush) begin
`ifdef NOP_PAD_EN
          state <= S_PAD;
`endif
        end else if (accept && bad) begin
          state        <= S_ERR;
          bus.oErr     <= 1'b1;
          bus.oErrCode <= illegal ? ERR_CLASS : ERR_RANGE;
        end
      end
    end
  end
endmodule

// File: tb/tb_rv_instr_encoder_loader.sv
// Directed bench for rv_instr_encoder_loader (DEPTH=4).
// The PAD step is compiled only with NOP_PAD_EN.
module tb_rv_instr_encoder_loader;
  logic iCLK = 1'b0;
  logic iRST_n;
  logic iStart;
`ifdef NOP_PAD_EN
  logic iFlush;
`endif
  int checks = 0;
  int failures = 0;

  always #5 iCLK = ~iCLK;

  rv_instr_encoder_loader_if #(.ADDR_W(8)) bus ();

  rv_instr_encoder_loader #(
    .ADDR_W    (8),
    .BASE_ADDR (0),
    .DEPTH     (4)
  ) dut (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .iStart (iStart),
`ifdef NOP_PAD_EN
    .iFlush (iFlush),
`endif
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic [3:0] c,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [20:0] imm);
    bus.iValid = v;
    bus.iClass = c;
    bus.iRd    = rd;
    bus.iRs1   = rs1;
    bus.iRs2   = rs2;
    bus.iImm   = imm;
  endtask

  // returns just after the posedge on which the request was taken
  task automatic wait_accept(input string tag);
    bit ok;
    ok = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus.oReady) begin
        ok = 1'b1;
        @(posedge iCLK);
        break;
      end
      @(negedge iCLK);
      #1;
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  task automatic start();
    @(negedge iCLK);
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
  endtask

  initial begin
    iRST_n = 1'b0;
    iStart = 1'b0;
`ifdef NOP_PAD_EN
    iFlush = 1'b0;
`endif
    bus.iWrReady = 1'b1;
    set_req(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 21'd0);
    repeat (2) @(negedge iCLK);
    chk("rst_ready", 64'(bus.oReady), 64'd0);
    chk("rst_wren", 64'(bus.oWrEn), 64'd0);
    chk("rst_addr", 64'(bus.oWrAddr), 64'd0);
    chk("rst_data", 64'(bus.oWrData), 64'd0);
    chk("rst_count", 64'(bus.oCount), 64'd0);
    chk("rst_err", 64'({bus.oErr, bus.oErrCode}), 64'd0);
    chk("rst_busy", 64'(bus.oBusy), 64'd0);
    iRST_n = 1'b1;

    // ADD x3,x1,x2
    start();
    chk("busy_load", 64'(bus.oBusy), 64'd1);
    set_req(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 21'd0);
    wait_accept("acc_add");
    @(negedge iCLK);
    bus.iValid = 1'b0;
    chk("add_wren", 64'(bus.oWrEn), 64'd1);
    chk("add_addr", 64'(bus.oWrAddr), 64'd0);
    chk("add_data", 64'(bus.oWrData), 64'h002081B3);
    @(negedge iCLK);
    chk("add_count", 64'(bus.oCount), 64'd1);
    chk("add_wren_off", 64'(bus.oWrEn), 64'd0);

    // SUB then LW back-to-back
    start();
    set_req(1'b1, 4'd1, 5'd5, 5'd6, 5'd7, 21'd0);
    wait_accept("acc_sub");
    @(negedge iCLK);
    set_req(1'b1, 4'd5, 5'd1, 5'd2, 5'd0, -21'sd4);
    chk("sub_addr", 64'(bus.oWrAddr), 64'd0);
    chk("sub_data", 64'(bus.oWrData), 64'h407302B3);
    chk("b2b_ready", 64'(bus.oReady), 64'd1);
    @(negedge iCLK);
    bus.iValid = 1'b0;
    chk("lw_wren", 64'(bus.oWrEn), 64'd1);
    chk("lw_addr", 64'(bus.oWrAddr), 64'd1);
    chk("lw_data", 64'(bus.oWrData), 64'hFFC12083);
    chk("b2b_count1", 64'(bus.oCount), 64'd1);
    @(negedge iCLK);
    chk("b2b_count2", 64'(bus.oCount), 64'd2);

    // BEQ with a stalled write port
    start();
    bus.iWrReady = 1'b0;
    set_req(1'b1, 4'd7, 5'd0, 5'd1, 5'd2, 21'd8);
    wait_accept("acc_beq");
    @(negedge iCLK);
    bus.iValid = 1'b0;
    chk("beq_data", 64'(bus.oWrData), 64'h00208463);
    chk("beq_stall_ready", 64'(bus.oReady), 64'd0);
    @(negedge iCLK);
    chk("beq_hold_en", 64'(bus.oWrEn), 64'd1);
    chk("beq_hold_data", 64'(bus.oWrData), 64'h00208463);
    chk("beq_hold_count", 64'(bus.oCount), 64'd0);
    @(negedge iCLK);
    chk("beq_hold_addr", 64'(bus.oWrAddr), 64'd0);
    bus.iWrReady = 1'b1;
    @(negedge iCLK);
    chk("beq_count", 64'(bus.oCount), 64'd1);
    chk("beq_wren_off", 64'(bus.oWrEn), 64'd0);

    // misaligned branch, then illegal class
    start();
    set_req(1'b1, 4'd7, 5'd0, 5'd1, 5'd2, 21'd7);
    wait_accept("acc_beq7");
    @(negedge iCLK);
    chk("rng_wren", 64'(bus.oWrEn), 64'd0);
    chk("rng_err", 64'({bus.oErr, bus.oErrCode}), 64'h6);
    chk("rng_ready", 64'(bus.oReady), 64'd0);
    @(negedge iCLK);
    chk("rng_ready2", 64'(bus.oReady), 64'd0);
    bus.iValid = 1'b0;
    start();
    chk("start_clr_err", 64'(bus.oErr), 64'd0);
    set_req(1'b1, 4'd12, 5'd0, 5'd0, 5'd0, 21'd0);
    wait_accept("acc_cls12");
    @(negedge iCLK);
    bus.iValid = 1'b0;
    chk("cls_err", 64'({bus.oErr, bus.oErrCode}), 64'h5);
    chk("cls_wren", 64'(bus.oWrEn), 64'd0);

    // LW imm boundary
    start();
    set_req(1'b1, 4'd5, 5'd1, 5'd2, 5'd0, 21'd2047);
    wait_accept("acc_lw2047");
    @(negedge iCLK);
    set_req(1'b1, 4'd5, 5'd1, 5'd2, 5'd0, 21'd2048);
    chk("lw2047_data", 64'(bus.oWrData), 64'h7FF12083);
    wait_accept("acc_lw2048");
    @(negedge iCLK);
    bus.iValid = 1'b0;
    chk("lw2048_err", 64'({bus.oErr, bus.oErrCode}), 64'h6);
    chk("lw2048_count", 64'(bus.oCount), 64'd1);

    // fill DEPTH=4 with SW, JAL, LW, OR; fifth refused
    start();
    set_req(1'b1, 4'd6, 5'd0, 5'd1, 5'd2, 21'd8);
    wait_accept("acc_sw");
    @(negedge iCLK);
    set_req(1'b1, 4'd8, 5'd1, 5'd0, 5'd0, -21'sd4);
    chk("sw_data", 64'(bus.oWrData), 64'h0020A423);
    wait_accept("acc_jal");
    @(negedge iCLK);
    set_req(1'b1, 4'd5, 5'd1, 5'd2, 5'd0, 21'd2047);
    chk("jal_data", 64'(bus.oWrData), 64'hFFDFF0EF);
    chk("jal_addr", 64'(bus.oWrAddr), 64'd1);
    wait_accept("acc_lw");
    @(negedge iCLK);
    set_req(1'b1, 4'd3, 5'd4, 5'd5, 5'd6, 21'd0);
    chk("lw3_addr", 64'(bus.oWrAddr), 64'd2);
    wait_accept("acc_or");
    @(negedge iCLK);
    set_req(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 21'd0);
    #1;
    chk("or_data", 64'(bus.oWrData), 64'h0062E233);
    chk("or_addr", 64'(bus.oWrAddr), 64'd3);
    chk("full_flag", 64'(bus.oFull), 64'd1);
    chk("full_ready", 64'(bus.oReady), 64'd0);
    @(negedge iCLK);
    chk("full_count", 64'(bus.oCount), 64'd4);
    @(negedge iCLK);
    chk("full_no_fifth", 64'({bus.oWrEn, bus.oCount}), 64'h04);
    bus.iValid = 1'b0;

    // iStart aborts a pending write
    start();
    bus.iWrReady = 1'b0;
    set_req(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 21'd0);
    wait_accept("acc_abort");
    @(negedge iCLK);
    bus.iValid = 1'b0;
    chk("abort_pend", 64'(bus.oWrEn), 64'd1);
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    chk("abort_wren", 64'(bus.oWrEn), 64'd0);
    chk("abort_count", 64'(bus.oCount), 64'd0);
    bus.iWrReady = 1'b1;
    set_req(1'b1, 4'd1, 5'd5, 5'd6, 5'd7, 21'd0);
    wait_accept("acc_after_abort");
    @(negedge iCLK);
    bus.iValid = 1'b0;
    chk("abort_ptr", 64'(bus.oWrAddr), 64'd0);

    // async reset mid-write
    start();
    bus.iWrReady = 1'b0;
    set_req(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 21'd0);
    wait_accept("acc_rst");
    @(negedge iCLK);
    bus.iValid = 1'b0;
    #2;
    iRST_n = 1'b0;
    #1;
    chk("async_rst_wren", 64'(bus.oWrEn), 64'd0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    bus.iWrReady = 1'b1;

`ifdef NOP_PAD_EN
    start();
    set_req(1'b1, 4'd0, 5'd3, 5'd1, 5'd2, 21'd0);
    wait_accept("acc_pad_add");
    @(negedge iCLK);
    bus.iValid = 1'b0;
    iFlush = 1'b1;
    @(negedge iCLK);
    iFlush = 1'b0;
    for (int i = 0; i < 6 && !(bus.oWrEn && bus.oWrAddr == 8'd1); i++)
      @(negedge iCLK);
    for (int a = 1; a < 4; a++) begin
      chk("pad_addr", 64'(bus.oWrAddr), 64'(a));
      chk("pad_data", 64'(bus.oWrData), 64'h13);
      @(negedge iCLK);
    end
    chk("pad_count", 64'(bus.oCount), 64'd4);
    chk("pad_full", 64'(bus.oFull), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rv_instr_encoder_loader.md
Name: rv_instr_encoder_loader

Overview:
Inverse of the single-cycle control decoder. Accepts field-level instruction requests (class, registers, immediate) over a valid/ready handshake. Encodes each request into an RV32I word for the supported subset and writes it sequentially into instruction memory through a stallable write port. Used as the program loader and stimulus generator for the uniciclo processor.

Parameters:
ADDR_W, 8, word-address width of the instruction-memory write port
BASE_ADDR, 0, first word address written after iStart
DEPTH, 256, words loadable before full (DEPTH <= 2**ADDR_W)

Ports:
iCLK  in  1  clock, rising edge
iRST_n  in  1  asynchronous active-low reset
iStart  in  1  pulse: abort any activity, pointer=BASE_ADDR, count=0, clear error, enter LOAD
iValid  in  1  request valid
oReady  out  1  request accepted when iValid&&oReady
iClass  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 JAL; 9-15 illegal
iRd  in  5  destination register
iRs1  in  5  source 1
iRs2  in  5  source 2
iImm  in  21  signed immediate (byte offset for BEQ/JAL)
oWrEn  out  1  memory write request
oWrAddr  out  ADDR_W  word address
oWrData  out  32  encoded instruction
iWrReady  in  1  memory accepts write when oWrEn&&iWrReady
oCount  out  ADDR_W+1  completed writes since iStart
oBusy  out  1  state != IDLE
oFull  out  1  state == FULL
oErr  out  1  sticky error
oErrCode  out  2  0 none, 1 illegal class, 2 immediate out of range/misaligned

Behaviour:
- Reset: state IDLE; oReady=0, oWrEn=0, oWrAddr=BASE_ADDR, oWrData=0, oCount=0, oErr=0, oErrCode=0, pointer=BASE_ADDR, issued=0.
- States: IDLE, LOAD, FULL, ERR (plus PAD under the optional feature).
- IDLE: waits for iStart, then enters LOAD.
- LOAD:
  - oReady = !(oWrEn && !iWrReady) && issued<DEPTH.
  - Accepted request is encoded combinationally. Next cycle: oWrEn=1, oWrAddr=pointer, oWrData=word; then pointer++ and issued++. Latency is 1 cycle from accept to oWrEn.
  - While oWrEn && !iWrReady: oWrEn, oWrAddr and oWrData are held stable.
  - oCount increments on each oWrEn&&iWrReady.
  - Back-to-back accept is allowed in the same cycle a write completes.
- Encodings (opcode):
  - R-type 0110011: funct7|rs2|rs1|funct3|rd. funct3: add/sub 000, slt 010, or 110, and 111. funct7 = 0100000 for SUB, 0 otherwise.
  - LW 0000011: imm[11:0]|rs1|010|rd.
  - SW 0100011: imm[11:5]|rs2|rs1|010|imm[4:0].
  - BEQ 1100011: imm[12]|imm[10:5]|rs2|rs1|000|imm[4:1]|imm[11].
  - JAL 1101111: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd.
- Range checks:
  - LW/SW: -2048..2047.
  - BEQ: -4096..4094, must be even.
  - JAL: -1048576..1048574, must be even.
  - R-type ignores iImm.
- Error handling: on an illegal class or failed range check, the request is accepted but not written. oErr=1, oErrCode is set, state goes to ERR, oReady=0. Any already-pending write still completes. Only iStart or reset leaves ERR.
- Full: when issued reaches DEPTH, state goes to FULL and oReady=0. The pending write drains normally. Pointer wrap never occurs.
- iStart has priority over everything in the same cycle, including iValid and a pending write. The pending write is dropped: oWrEn=0 the next cycle.
- Asynchronous reset mid-write drops oWrEn immediately.

Optional Feature:
Macro NOP_PAD_EN.
- Defined: adds input port iFlush (1 bit). iFlush in LOAD (with no error) enters PAD. PAD writes 32'h00000013 (addi x0,x0,0) to each remaining address, one per completed write, honouring iWrReady. oReady=0 during PAD. After the write where issued reaches DEPTH, state goes to FULL. iStart aborts PAD.
- Undefined: no iFlush port, no PAD state; unwritten memory is left untouched.

Decomposition:
- Package rv_enc_pkg: class codes, opcodes, funct3/funct7 constants, NOP word, error codes, state enum.
- One natural sub-module, rv_field_encoder: purely combinational fields -> {word, illegal, range_err}. The top level holds the FSM, pointer, counters and output register.

Test Plan:
- ADD x3,x1,x2 (class 0, rd 3, rs1 1, rs2 2) after iStart -> cycle+1 oWrEn=1, oWrAddr=0, oWrData=32'h002081B3; oCount=1 after iWrReady.
- SUB x5,x6,x7 then LW x1,-4(x2) back-to-back, iWrReady=1 -> addr 0: 32'h407302B3, addr 1: 32'hFFC12083 on consecutive cycles.
- BEQ x1,x2,+8 with iWrReady low 3 cycles -> oWrData=32'h00208463 held stable, oReady=0, oCount unchanged until ready.
- BEQ with imm=7, then class 12 after iStart -> no write; oErr=1, oErrCode=2, then 1; oReady=0 until iStart.
- DEPTH=4, five requests -> four writes to addresses 0-3, oFull=1, fifth request never accepted; iStart with a pending write -> oWrEn=0, pointer=0.
- NOP_PAD_EN, DEPTH=4: one ADD, then iFlush -> addresses 1-3 = 32'h00000013, oCount=4, oFull=1.
